lut_mux128: RTL and testbench



---
 rtl/lut_mux_pkg.sv | 11 +
 rtl/lut3_cell.sv | 25 ++
 rtl/lut_mux128.sv | 34 +++
 tb/tb_lut_mux128.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/lut_mux_pkg.sv
// Shared constants for the LUT-based wide multiplexer.
package lut_mux_pkg;

    // LUT3 truth table for a 2:1 mux indexed by {I2=sel, I1=b, I0=a}:
    // low nibble (sel=0) passes I1 (4'hC), high nibble (sel=1) passes I0 (4'hA).
    localparam logic [7:0] LUT3_MUX_INIT = 8'hAC;

    // Default datapath width of the characterisation block.
    localparam int LUT_MUX_DEFAULT_WIDTH = 128;

endpackage : lut_mux_pkg

// File: rtl/lut3_cell.sv
// Behavioural 3-input LUT: o = INIT[{i2,i1,i0}].
// Written as a tree of 2:1 selections so the flow can map it to one LUT3.
// When i2 is unknown and both cofactors agree, the known common value is kept.
module lut3_cell
    import lut_mux_pkg::*;
#(
    parameter logic [7:0] INIT = LUT3_MUX_INIT
) (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    output logic o
);

    logic cof_lo;   // result for i2 = 0, table entries 0..3
    logic cof_hi;   // result for i2 = 1, table entries 4..7

    // Decode i1/i0 within each half of the truth table, then pick a half with i2.
    always_comb begin
        cof_lo = i1 ? (i0 ? INIT[3] : INIT[2]) : (i0 ? INIT[1] : INIT[0]);
        cof_hi = i1 ? (i0 ? INIT[7] : INIT[6]) : (i0 ? INIT[5] : INIT[4]);
        o      = i2 ? cof_hi : cof_lo;
    end

endmodule : lut3_cell

// File: rtl/lut_mux128.sv
// 128-bit 2:1 multiplexer, y = c ? a : b, one LUT3 cell per bit.
// Purely combinational; clock and reset exist only for the harness interface.
module lut_mux128
    import lut_mux_pkg::*;
#(
    parameter int         WIDTH    = LUT_MUX_DEFAULT_WIDTH,
    parameter logic [7:0] LUT_INIT = LUT3_MUX_INIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             c,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // The datapath holds no state, so the harness clock and reset are
    // deliberately left without a functional load.
    logic unused_harness;
    assign unused_harness = ^{clock, reset};

    // One LUT3 per bit; the select is broadcast to every cell.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        lut3_cell #(
            .INIT (LUT_INIT)
        ) u_cell (
            .i0 (a[gi]),
            .i1 (b[gi]),
            .i2 (c),
            .o  (y[gi])
        );
    end

endmodule : lut_mux128

// File: tb/tb_lut_mux128.sv
// Directed self-checking bench for lut_mux128 and a standalone lut3_cell.
module tb_lut_mux128;

    localparam int W = 128;

    logic         clock;
    logic         reset;
    logic         c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;

    // Standalone cell for the exhaustive truth-table sweep.
    logic cell_i0, cell_i1, cell_i2, cell_o;

    int checks = 0;
    int errors = 0;

    lut_mux128 dut (
        .clock (clock),
        .reset (reset),
        .c     (c),
        .a     (a),
        .b     (b),
        .y     (y)
    );

    lut3_cell #(.INIT(8'hAC)) u_cell (
        .i0 (cell_i0),
        .i1 (cell_i1),
        .i2 (cell_i2),
        .o  (cell_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-14s y=%h", tag, obs);
        end else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive after the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic sel, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clock);
        reset = r;
        c     = sel;
        a     = va;
        b     = vb;
        @(posedge clock);
        #1;
    endtask

    localparam logic [W-1:0] PAT_A = 128'hABCDABCD_ABCDABCD_ABCDABCD_ABCDABCD;
    localparam logic [W-1:0] PAT_B = 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD;
    localparam logic [W-1:0] ONES  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    localparam logic [W-1:0] BIT0   = 128'h00000000_00000000_00000000_00000001;
    localparam logic [W-1:0] BIT63  = 128'h00000000_00000000_80000000_00000000;
    localparam logic [W-1:0] BIT127 = 128'h80000000_00000000_00000000_00000000;
    localparam logic [W-1:0] NBIT0   = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE;
    localparam logic [W-1:0] NBIT63  = 128'hFFFFFFFF_FFFFFFFF_7FFFFFFF_FFFFFFFF;
    localparam logic [W-1:0] NBIT127 = 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    // Hand-written table of expected cell outputs indexed by {c,b,a}.
    logic [7:0] cell_exp;

    initial begin
        reset = 1'b1; c = 1'b0; a = '0; b = '0;
        cell_i0 = 1'b0; cell_i1 = 1'b0; cell_i2 = 1'b0;

        // Under reset with zero inputs the output is simply zero.
        step(1'b1, 1'b0, '0, '0);
        check("reset_zero", y, '0);

        // Reset held, c=1, a all ones, b zero: reset must not force y.
        step(1'b1, 1'b1, ONES, '0);
        check("reset_pass_a", y, ONES);
        step(1'b1, 1'b1, ONES, '0);
        check("reset_hold", y, ONES);

        // Main patterns.
        step(1'b0, 1'b1, PAT_A, PAT_B);
        check("sel_a", y, PAT_A);
        step(1'b0, 1'b0, PAT_A, PAT_B);
        check("sel_b", y, PAT_B);

        // Toggle c 0 -> 1 -> 0 on consecutive cycles: no lag.
        step(1'b0, 1'b0, PAT_A, PAT_B);
        check("tog_cyc0", y, PAT_B);
        step(1'b0, 1'b1, PAT_A, PAT_B);
        check("tog_cyc1", y, PAT_A);
        step(1'b0, 1'b0, PAT_A, PAT_B);
        check("tog_cyc2", y, PAT_B);

        // Equal inputs: output independent of select.
        step(1'b0, 1'b0, PAT_A, PAT_A);
        check("eq_c0", y, PAT_A);
        step(1'b0, 1'b1, PAT_B, PAT_B);
        check("eq_c1", y, PAT_B);

        // Walking one, c=1 selects the single-bit word.
        step(1'b0, 1'b1, BIT0, NBIT0);
        check("walk_a_0", y, BIT0);
        step(1'b0, 1'b1, BIT63, NBIT63);
        check("walk_a_63", y, BIT63);
        step(1'b0, 1'b1, BIT127, NBIT127);
        check("walk_a_127", y, BIT127);

        // Same vectors, c=0 selects the inverted word.
        step(1'b0, 1'b0, BIT0, NBIT0);
        check("walk_b_0", y, NBIT0);
        step(1'b0, 1'b0, BIT63, NBIT63);
        check("walk_b_63", y, NBIT63);
        step(1'b0, 1'b0, BIT127, NBIT127);
        check("walk_b_127", y, NBIT127);

        // Exhaustive sweep of one cell: 8'hAC = 1010_1100.
        cell_exp = 8'b1010_1100;
        for (int idx = 0; idx < 8; idx++) begin
            @(negedge clock);
            cell_i2 = idx[2];
            cell_i1 = idx[1];
            cell_i0 = idx[0];
            #1;
            checks++;
            assert (cell_o === cell_exp[idx]) begin
                $display("check cell_%0d        o=%b", idx, cell_o);
            end else begin
                errors++;
                $error("FAIL cell_%0d observed=%b expected=%b", idx, cell_o, cell_exp[idx]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lut_mux128
